// File: rtl/sid_pot_scan.sv
// sid_pot_scan -- SID paddle (POTX/POTY) scan controller.
//
// Runs every pot channel in lockstep through a discharge phase and a
// charge-timing phase. Both phases are 256 phi2 ticks long. The first rise
// seen on each synchronized pad during the timing phase is latched into a
// shadow register. All channels are committed together in a one-CLK COMMIT
// state, which also pulses UPDATE.
//
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   CLKen    phi2 tick, one CLK wide; every phase count advances on it
//   ENABLE   scan enable; low parks all channels discharged (IDLE)
//   POT_IN   raw pad inputs, asynchronous to CLK
//   POT_OE   1 = pull pad to ground, 0 = release pad
//   RD_SEL   channel select for RD_DATA
//   RD_DATA  committed value of the selected channel; 8'h00 when out of range
//   UPDATE   one-CLK pulse while the COMMIT state is active
//   TIMEOUT  per channel; 1 = last committed window saw no rise
module sid_pot_scan #(
  parameter int NUM_POTS = 2,
  parameter int SEL_W    = 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLKen,
  input  logic                ENABLE,
  input  logic [NUM_POTS-1:0] POT_IN,
  output logic [NUM_POTS-1:0] POT_OE,
  input  logic [SEL_W-1:0]    RD_SEL,
  output logic [7:0]          RD_DATA,
  output logic                UPDATE,
  output logic [NUM_POTS-1:0] TIMEOUT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCHARGE,
    S_SAMPLE,
    S_COMMIT
  } state_t;

  state_t                   state_q;
  logic [7:0]               cnt_q;
  logic [NUM_POTS-1:0]      sync1_q;
  logic [NUM_POTS-1:0]      sync2_q;
  logic [NUM_POTS-1:0]      cap_q;
  logic [NUM_POTS-1:0]      cap_d;
  logic [NUM_POTS-1:0][7:0] shadow_q;
  logic [NUM_POTS-1:0][7:0] shadow_d;
  logic [NUM_POTS-1:0][7:0] commit_q;
  logic [NUM_POTS-1:0]      oe_q;
  logic [NUM_POTS-1:0]      timeout_q;
  logic                     update_q;
  logic                     last_tick;

  assign last_tick = (cnt_q == 8'hFF);

  // First-rise capture for the current tick. Already-captured channels keep
  // their value, so a drop and re-rise inside one window is ignored.
  always_comb begin
    cap_d    = cap_q;
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_POTS; i++) begin
      if (!cap_q[i] && sync2_q[i]) begin
        cap_d[i]    = 1'b1;
        shadow_d[i] = cnt_q;
      end
    end
  end

  // Shadow values are data only. They are cleared on entry to SAMPLE and
  // only read behind cap_q, so they need no reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_DISCHARGE && CLKen && last_tick) begin
      shadow_q <= '0;
    end else if (state_q == S_SAMPLE && CLKen) begin
      shadow_q <= shadow_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_DISCHARGE;
      cnt_q     <= 8'h00;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cap_q     <= '0;
      commit_q  <= '0;
      oe_q      <= '1;
      timeout_q <= '0;
      update_q  <= 1'b0;
    end else begin
      sync1_q  <= POT_IN;
      sync2_q  <= sync1_q;
      update_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= 8'h00;
          oe_q  <= '1;
          if (ENABLE) state_q <= S_DISCHARGE;
        end
        S_DISCHARGE: begin
          if (!ENABLE) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h00;
            oe_q    <= '1;
          end else if (CLKen) begin
            // The 8-bit counter wraps 255 -> 0 on the phase change.
            cnt_q <= cnt_q + 8'd1;
            if (last_tick) begin
              cap_q   <= '0;
              oe_q    <= '0;
              state_q <= S_SAMPLE;
            end
          end
        end
        S_SAMPLE: begin
          if (!ENABLE) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h00;
            oe_q    <= '1;
          end else if (CLKen) begin
            cnt_q <= cnt_q + 8'd1;
            cap_q <= cap_d;
            if (last_tick) begin
              // Commit uses this tick's capture result, so a rise at
              // count 255 is committed. Committing on entry to COMMIT
              // makes RD_DATA/TIMEOUT change on the edge that raises UPDATE.
              for (int i = 0; i < NUM_POTS; i++) begin
                commit_q[i] <= cap_d[i] ? shadow_d[i] : 8'hFF;
              end
              timeout_q <= ~cap_d;
              update_q  <= 1'b1;
              oe_q      <= '1;
              state_q   <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          // A CLKen that arrives in this cycle is intentionally dropped.
          cnt_q   <= 8'h00;
          oe_q    <= '1;
          state_q <= ENABLE ? S_DISCHARGE : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 8'h00;
          oe_q    <= '1;
        end
      endcase
    end
  end

  always_comb begin
    RD_DATA = 8'h00;
    for (int i = 0; i < NUM_POTS; i++) begin
      if (32'(RD_SEL) == i) RD_DATA = commit_q[i];
    end
  end

  assign POT_OE  = oe_q;
  assign UPDATE  = update_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_sid_pot_scan.sv
module tb_sid_pot_scan;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         CLKen;
  logic         ENABLE;
  logic [1:0]   POT_IN;
  logic [1:0]   POT_OE;
  logic [1:0]   RD_SEL;
  logic [7:0]   RD_DATA;
  logic         UPDATE;
  logic [1:0]   TIMEOUT;

  int           n_pass  = 0;
  int           n_total = 0;

  // Reference model: committed values and timeouts as the bench expects them.
  logic [7:0]   exp_val [2];
  logic [1:0]   exp_to;
  // Per-channel pad level for each SAMPLE tick of the next window.
  logic [255:0] pat0;
  logic [255:0] pat1;

  sid_pot_scan #(.NUM_POTS(2), .SEL_W(2)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .CLKen   (CLKen),
    .ENABLE  (ENABLE),
    .POT_IN  (POT_IN),
    .POT_OE  (POT_OE),
    .RD_SEL  (RD_SEL),
    .RD_DATA (RD_DATA),
    .UPDATE  (UPDATE),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One phi2 tick: CLKen high across exactly one rising edge.
  task automatic tick();
    CLKen = 1'b1;
    @(posedge CLK);
    #1;
    CLKen = 1'b0;
  endtask

  function automatic logic [255:0] step_pat(input int r);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < 256; k++) if (k >= r) p[k] = 1'b1;
    return p;
  endfunction

  // {found, tick index of first high level}
  function automatic logic [8:0] first_rise(input logic [255:0] p);
    for (int k = 0; k < 256; k++) if (p[k]) return {1'b1, 8'(k)};
    return 9'h000;
  endfunction

  // One scan window from the start of DISCHARGE (counter 0).
  // The pad levels are applied four CLK ahead of each tick, so the
  // synchronizer has settled by the time the tick samples them.
  task automatic run_window(input logic [1:0] dis_lvl, input bit clken_commit,
                            input int stop_at, input bit rst_abort, input string tag);
    logic [8:0] f0, f1;
    POT_IN = dis_lvl;
    for (int i = 0; i < 256; i++) begin
      n_total++;
      if (POT_OE !== 2'b11) $display("FAIL %s oe_discharge tick %0d: got %b want 11", tag, i, POT_OE);
      else n_pass++;
      idle(3);
      tick();
    end
    for (int k = 0; k < stop_at; k++) begin
      POT_IN = {pat1[k], pat0[k]};
      n_total++;
      if (POT_OE !== 2'b00) $display("FAIL %s oe_sample tick %0d: got %b want 00", tag, k, POT_OE);
      else n_pass++;
      if (k == 255) begin
        RD_SEL = 2'd0;
        #1;
        n_total++;
        if (RD_DATA !== exp_val[0] || UPDATE !== 1'b0)
          $display("FAIL %s early_commit: rd=%h upd=%b want rd=%h upd=0", tag, RD_DATA, UPDATE, exp_val[0]);
        else n_pass++;
      end
      idle(3);
      tick();
    end

    if (stop_at < 256) begin
      if (rst_abort) begin
        #2 RST_N = 1'b0;
        #1;
        exp_val[0] = 8'h00;
        exp_val[1] = 8'h00;
        exp_to     = 2'b00;
        n_total++;
        if (POT_OE !== 2'b11 || UPDATE !== 1'b0 || TIMEOUT !== 2'b00)
          $display("FAIL %s async_reset: oe=%b upd=%b to=%b want 11/0/00", tag, POT_OE, UPDATE, TIMEOUT);
        else n_pass++;
        for (int s = 0; s < 2; s++) begin
          RD_SEL = 2'(s);
          #1;
          n_total++;
          if (RD_DATA !== 8'h00) $display("FAIL %s reset_rd%0d: got %h want 00", tag, s, RD_DATA);
          else n_pass++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
      end else begin
        ENABLE = 1'b0;
        idle(1);
        n_total++;
        if (POT_OE !== 2'b11 || UPDATE !== 1'b0)
          $display("FAIL %s abort_oe: oe=%b upd=%b want 11/0", tag, POT_OE, UPDATE);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
          tick();
          idle(3);
          n_total++;
          if (POT_OE !== 2'b11 || UPDATE !== 1'b0)
            $display("FAIL %s idle_hold %0d: oe=%b upd=%b want 11/0", tag, j, POT_OE, UPDATE);
          else n_pass++;
        end
        n_total++;
        if (TIMEOUT !== exp_to) $display("FAIL %s abort_timeout: got %b want %b", tag, TIMEOUT, exp_to);
        else n_pass++;
        for (int s = 0; s < 2; s++) begin
          RD_SEL = 2'(s);
          #1;
          n_total++;
          if (RD_DATA !== exp_val[s]) $display("FAIL %s abort_rd%0d: got %h want %h", tag, s, RD_DATA, exp_val[s]);
          else n_pass++;
        end
      end
      return;
    end

    f0 = first_rise(pat0);
    f1 = first_rise(pat1);
    exp_val[0] = f0[8] ? f0[7:0] : 8'hFF;
    exp_val[1] = f1[8] ? f1[7:0] : 8'hFF;
    exp_to     = {~f1[8], ~f0[8]};
    n_total++;
    if (UPDATE !== 1'b1) $display("FAIL %s update_pulse: got %b want 1", tag, UPDATE);
    else n_pass++;
    n_total++;
    if (TIMEOUT !== exp_to) $display("FAIL %s timeout: got %b want %b", tag, TIMEOUT, exp_to);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      RD_SEL = 2'(s);
      #1;
      n_total++;
      if (s < 2 && RD_DATA !== exp_val[s]) $display("FAIL %s rd%0d: got %h want %h", tag, s, RD_DATA, exp_val[s]);
      else if (s == 2 && RD_DATA !== 8'h00) $display("FAIL %s rd_out_of_range: got %h want 00", tag, RD_DATA);
      else n_pass++;
    end
    RD_SEL = 2'd0;
    if (clken_commit) tick();
    else idle(1);
    n_total++;
    if (UPDATE !== 1'b0 || POT_OE !== 2'b11)
      $display("FAIL %s post_commit: upd=%b oe=%b want 0/11", tag, UPDATE, POT_OE);
    else n_pass++;
  endtask

  task automatic test_reset();
    RST_N  = 1'b0;
    CLKen  = 1'b0;
    ENABLE = 1'b1;
    POT_IN = 2'b00;
    RD_SEL = 2'd0;
    exp_val[0] = 8'h00;
    exp_val[1] = 8'h00;
    exp_to     = 2'b00;
    idle(3);
    n_total++;
    if (POT_OE !== 2'b11 || UPDATE !== 1'b0 || TIMEOUT !== 2'b00)
      $display("FAIL reset_outputs: oe=%b upd=%b to=%b want 11/0/00", POT_OE, UPDATE, TIMEOUT);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      RD_SEL = 2'(s);
      #1;
      n_total++;
      if (RD_DATA !== 8'h00) $display("FAIL reset_rd%0d: got %h want 00", s, RD_DATA);
      else n_pass++;
    end
    RD_SEL = 2'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    pat0 = step_pat(100);
    pat1 = step_pat(37);
    run_window(2'b00, 1'b0, 256, 1'b0, "basic");
  endtask

  task automatic test_timeout();
    pat0 = '0;
    pat1 = '0;
    run_window(2'b00, 1'b0, 256, 1'b0, "all_low");
    pat0 = step_pat(5);
    pat1 = step_pat(5);
    run_window(2'b00, 1'b0, 256, 1'b0, "rise5");
  endtask

  task automatic test_held_high();
    pat0 = '1;
    pat1 = '1;
    run_window(2'b11, 1'b0, 256, 1'b0, "held_high");
  endtask

  task automatic test_glitch();
    pat0 = step_pat(60);
    pat0[20] = 1'b1;
    pat1 = step_pat(int'($urandom_range(0, 255)));
    run_window(2'b00, 1'b0, 256, 1'b0, "glitch");
  endtask

  task automatic test_random();
    for (int w = 0; w < 4; w++) begin
      pat0 = step_pat(int'($urandom_range(0, 300)));
      pat1 = step_pat(int'($urandom_range(0, 300)));
      for (int k = 0; k < 256; k++) begin
        if ($urandom_range(0, 99) == 0) pat0[k] = ~pat0[k];
        if ($urandom_range(0, 99) == 0) pat1[k] = ~pat1[k];
      end
      run_window(2'($urandom_range(0, 3)), 1'b0, 256, 1'b0, "random");
    end
  endtask

  task automatic test_abort();
    pat0 = step_pat(50);
    pat1 = step_pat(200);
    run_window(2'b00, 1'b0, 128, 1'b0, "abort");
    ENABLE = 1'b1;
    idle(1);
    pat0 = step_pat(10);
    pat1 = step_pat(222);
    run_window(2'b00, 1'b0, 256, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    pat0 = step_pat(int'($urandom_range(0, 255)));
    pat1 = step_pat(int'($urandom_range(0, 255)));
    run_window(2'b00, 1'b1, 256, 1'b0, "commit_clken");
    pat0 = step_pat(int'($urandom_range(1, 255)));
    pat1 = step_pat(int'($urandom_range(1, 255)));
    run_window(2'b00, 1'b0, 256, 1'b0, "after_drop");
  endtask

  task automatic test_reset_mid();
    pat0 = step_pat(30);
    pat1 = step_pat(7);
    run_window(2'b00, 1'b0, 50, 1'b1, "reset_mid");
    pat0 = step_pat(77);
    pat1 = '0;
    run_window(2'b00, 1'b0, 256, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_held_high();
    test_glitch();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
